// File: rtl/fm_sb_init_seq_pkg.sv
// fm_sb_pkg: shared types and defaults for the spy-memory initialisation sequencer.
package fm_sb_pkg;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_QUIESCE = 2'd1,
        ST_CLEAR   = 2'd2,
        ST_DONE    = 2'd3
    } init_state_e;

    // Cycles freeze is held before the first clear write.
    localparam int unsigned QUIESCE_CYC_DEF = 4;

    // Word written to every spy-memory location.
    localparam logic [31:0] INIT_PATTERN_DEF = '0;

    // Width of a counter holding 0..n-1, never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fm_sb_init_seq_addr_gen.sv
// fm_sb_init_addr_gen: shared write address / buffer index counter pair.
// Stalls on adv_i low, wraps the address, steps to the next buffer without a
// bubble and flags the final word. With FM_SB_INIT_SKIP_MASK_EN defined, buffers
// set in the mask captured at load are stepped over.
module fm_sb_init_addr_gen
    import fm_sb_pkg::*;
#(
    parameter int unsigned SB_N   = 64,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned IDX_W  = idx_width(SB_N)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              adv_i,
`ifdef FM_SB_INIT_SKIP_MASK_EN
    input  logic [SB_N-1:0]   skip_mask_i,
`endif
    output logic [ADDR_W-1:0] addr_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic [IDX_W-1:0]  idx_next_o,
    output logic              last_o,
    output logic              none_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  first_idx;
    logic [IDX_W-1:0]  succ_idx;
    logic              has_succ;
    logic              addr_end;

    assign addr_end = &addr_q;

`ifdef FM_SB_INIT_SKIP_MASK_EN
    logic [SB_N-1:0] mask_q, mask_d;
    logic            first_found;

    // Lowest unmasked buffer in the incoming mask, taken when a sequence starts.
    always_comb begin
        first_idx   = '0;
        first_found = 1'b0;
        for (int unsigned i = 0; i < SB_N; i++) begin
            if (!skip_mask_i[i] && !first_found) begin
                first_idx   = IDX_W'(i);
                first_found = 1'b1;
            end
        end
    end

    // Nearest unmasked buffer above the current one.
    always_comb begin
        succ_idx = idx_q;
        has_succ = 1'b0;
        for (int unsigned i = 0; i < SB_N; i++) begin
            if (i > 32'(idx_q) && !mask_q[i] && !has_succ) begin
                succ_idx = IDX_W'(i);
                has_succ = 1'b1;
            end
        end
    end

    assign none_o = &mask_q;
`else
    assign first_idx = '0;
    assign succ_idx  = idx_q + IDX_W'(1);
    assign has_succ  = (idx_q != IDX_W'(SB_N - 1));
    assign none_o    = 1'b0;
`endif

    // Next address/index: reload on start, otherwise step on each accepted write.
    always_comb begin
        addr_d = addr_q;
        idx_d  = idx_q;
`ifdef FM_SB_INIT_SKIP_MASK_EN
        mask_d = mask_q;
`endif
        if (load_i) begin
            addr_d = '0;
            idx_d  = first_idx;
`ifdef FM_SB_INIT_SKIP_MASK_EN
            mask_d = skip_mask_i;
`endif
        end else if (adv_i) begin
            addr_d = addr_q + ADDR_W'(1);
            if (addr_end && has_succ) begin
                idx_d = succ_idx;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q <= '0;
            idx_q  <= '0;
`ifdef FM_SB_INIT_SKIP_MASK_EN
            mask_q <= '0;
`endif
        end else begin
            addr_q <= addr_d;
            idx_q  <= idx_d;
`ifdef FM_SB_INIT_SKIP_MASK_EN
            mask_q <= mask_d;
`endif
        end
    end

    assign addr_o     = addr_q;
    assign idx_o      = idx_q;
    assign idx_next_o = idx_d;
    assign last_o     = addr_end & ~has_succ;

endmodule

// File: rtl/fm_sb_init_seq.sv
// fm_sb_init_seq: spy-memory initialisation sequencer.
// On a rising edge of init_spy_mem it freezes every buffer, waits QUIESCE_CYC
// cycles, then writes INIT_PATTERN to every word of every buffer through one
// shared write port. Optional macro FM_SB_INIT_SKIP_MASK_EN adds skip_mask.
module fm_sb_init_seq
    import fm_sb_pkg::*;
#(
    parameter int unsigned       SB_N         = 64,
    parameter int unsigned       ADDR_W       = 10,
    parameter int unsigned       DATA_W       = 32,
    parameter int unsigned       QUIESCE_CYC  = QUIESCE_CYC_DEF,
    parameter logic [DATA_W-1:0] INIT_PATTERN = DATA_W'(INIT_PATTERN_DEF),
    localparam int unsigned      IDX_W        = idx_width(SB_N)
) (
    input  logic              axi_clk,
    input  logic              axi_reset,
    input  logic              init_spy_mem,
    input  logic [SB_N-1:0]   freeze_in,
`ifdef FM_SB_INIT_SKIP_MASK_EN
    input  logic [SB_N-1:0]   skip_mask,
`endif
    output logic [SB_N-1:0]   freeze_out,
    output logic [SB_N-1:0]   mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_wr_ready,
    output logic              init_busy,
    output logic              init_done,
    output logic [IDX_W-1:0]  init_sb_idx
);

    localparam int unsigned QW = idx_width(QUIESCE_CYC);

    init_state_e       state_q, state_d;
    logic              init_prev_q;
    logic [QW-1:0]     qcnt_q, qcnt_d;
    logic [SB_N-1:0]   we_q, we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              start;
    logic              adv;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_next;
    logic              last_word;
    logic              none_left;

    assign start = init_spy_mem & ~init_prev_q &
                   ((state_q == ST_IDLE) | (state_q == ST_DONE));
    assign adv   = (state_q == ST_CLEAR) & mem_wr_ready;

    fm_sb_init_addr_gen #(
        .SB_N   (SB_N),
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W)
    ) u_addr_gen (
        .clk_i       (axi_clk),
        .rst_i       (axi_reset),
        .load_i      (start),
        .adv_i       (adv),
`ifdef FM_SB_INIT_SKIP_MASK_EN
        .skip_mask_i (skip_mask),
`endif
        .addr_o      (mem_addr),
        .idx_o       (idx),
        .idx_next_o  (idx_next),
        .last_o      (last_word),
        .none_o      (none_left)
    );

    // Next state and registered outputs; the strobe follows the index the
    // counter pair will hold after this edge so it stays bubble-free.
    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        we_d    = we_q;
        busy_d  = busy_q;
        done_d  = done_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_QUIESCE;
                    qcnt_d  = '0;
                    we_d    = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            ST_QUIESCE: begin
                qcnt_d = qcnt_q + QW'(1);
                if (qcnt_q == QW'(QUIESCE_CYC - 1)) begin
                    if (none_left) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_CLEAR;
                        we_d    = SB_N'(1) << idx_next;
                    end
                end
            end
            ST_CLEAR: begin
                if (mem_wr_ready) begin
                    if (last_word) begin
                        state_d = ST_DONE;
                        we_d    = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        we_d = SB_N'(1) << idx_next;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                we_d    = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, edge-detect and output registers.
    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            state_q     <= ST_IDLE;
            init_prev_q <= 1'b1;
            qcnt_q      <= '0;
            we_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_prev_q <= init_spy_mem;
            qcnt_q      <= qcnt_d;
            we_q        <= we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign freeze_out  = freeze_in | {SB_N{busy_q}};
    assign mem_we      = we_q;
    assign mem_wdata   = INIT_PATTERN;
    assign init_busy   = busy_q;
    assign init_done   = done_q;
    assign init_sb_idx = idx;

endmodule

// File: doc/fm_sb_init_seq.md
# fm_sb_init_seq

Spy-memory initialisation sequencer for the fast-monitoring spy-buffer subsystem. It sits between the spy control register block (level `init_spy_mem`, per-buffer `freeze`) and the spy-buffer memories. On a request it forces every mapped spy buffer frozen, drains in-flight traffic, then walks a single shared write port across all buffers, one buffer at a time, writing a fixed pattern to every address. It reports busy/done status back to the control registers.

## Interface
- `SB_N`, 64: number of mapped spy buffers.
- `ADDR_W`, 10: spy-memory address width; depth = 2^ADDR_W words.
- `DATA_W`, 32: spy-memory word width.
- `QUIESCE_CYC`, 4: cycles freeze is held before the first clear write (≥1).
- `INIT_PATTERN`, 0: `DATA_W`-bit value written to every word.
- `axi_clk`  in  1  clock.
- `axi_reset`  in  1  asynchronous, active-high reset.
- `init_spy_mem`  in  1  level from control register; a 0→1 transition requests initialisation.
- `freeze_in`  in  SB_N  per-buffer freeze from the freeze/playback mask logic.
- `freeze_out`  out  SB_N  freeze to buffers: `freeze_in` while idle, all-ones while busy.
- `mem_we`  out  SB_N  one-hot write strobe to the selected buffer.
- `mem_addr`  out  ADDR_W  shared write address.
- `mem_wdata`  out  DATA_W  always `INIT_PATTERN`.
- `mem_wr_ready`  in  1  write accepted in any cycle where `mem_we`≠0 and this is 1.
- `init_busy`  out  1  sequence in progress.
- `init_done`  out  1  sticky completion flag; cleared on the next start.
- `init_sb_idx`  out  $clog2(SB_N)  index of the buffer being cleared (status).

## Operation
- States: IDLE, QUIESCE, CLEAR, DONE.
- Start: a registered copy `init_prev` of `init_spy_mem`. Start = `init_spy_mem & ~init_prev`, honoured only in IDLE or DONE. A rising edge in QUIESCE or CLEAR is ignored; no queueing.
- IDLE/DONE → QUIESCE on start: `init_busy`=1, `init_done`=0, quiesce counter=0, `init_sb_idx`=0, `mem_addr`=0.
- QUIESCE: `freeze_out` all-ones, `mem_we`=0. The counter increments each cycle. When the count reaches `QUIESCE_CYC`-1 → CLEAR.
- CLEAR: `mem_we` = one-hot(`init_sb_idx`). On an accepted write, `mem_addr` increments. On an accepted write at address 2^ADDR_W-1, `mem_addr` wraps to 0 and `init_sb_idx` increments with no bubble cycle. On an accepted write at the last address of buffer SB_N-1 → DONE.
- `mem_wr_ready`=0 holds address, index and strobe unchanged (stall). There is no timeout.
- DONE: `init_busy`=0, `init_done`=1, `mem_we`=0, `freeze_out`=`freeze_in`. DONE behaves as IDLE for start detection.
- Counter widths: `mem_addr` wraps naturally at ADDR_W bits. `init_sb_idx` never exceeds SB_N-1, including for non-power-of-two SB_N.

## Timing
- All outputs are registered, except `freeze_out`, which is `freeze_in` OR'd with a registered busy mask (0-cycle path from `freeze_in`).
- Reset values: state IDLE, `init_prev`=1, `mem_we`=0, `mem_addr`=0, `init_sb_idx`=0, `init_busy`=0, `init_done`=0.
- Because `init_prev` resets to 1, a level held high through reset does not trigger a start; a fresh 0→1 is required.
- Start sampled at edge k → `init_busy` and all-ones freeze are visible after edge k.
- First `mem_we` is visible after edge k+`QUIESCE_CYC`.
- With `mem_wr_ready` tied high: exactly SB_N·2^ADDR_W write cycles, then `init_done` rises one edge after the final accepted write.
- Reset mid-sequence: all outputs return to reset values asynchronously. Memory contents are undefined and no restart occurs.

## Configuration
- `FM_SB_INIT_SKIP_MASK_EN` defined: adds input `skip_mask` [SB_N], sampled at start.
  - CLEAR jumps over masked buffers; no writes or cycles are spent on them.
  - Masked buffers still receive all-ones freeze while busy.
  - All-masked: QUIESCE → DONE directly.
- Macro undefined: no `skip_mask` port; every buffer is cleared.

## Structure
- `fm_sb_pkg` holds the state enum type, the default `INIT_PATTERN`, and the `QUIESCE_CYC` default.
- One sub-module, `fm_sb_init_addr_gen`: the address/buffer-index counter pair with stall, wrap, last-word detection and (under the macro) skip logic.
- The FSM, edge detect and freeze OR remain in the top.

## Test plan
- SB_N=4, ADDR_W=3, QUIESCE_CYC=4, ready tied 1; pulse `init_spy_mem` 0→1 → 4 idle-write cycles, then 32 writes with addresses 0..7 per buffer and `mem_we` 0001,0010,0100,1000; `init_done`=1 one edge after the last write.
- Same config, `mem_wr_ready` low for 3 cycles at buffer 2 address 5 → address, strobe and index held; total write cycles = 35; no skipped or duplicated address.
- Rising edge on `init_spy_mem` during CLEAR → ignored, single sequence only. A new rising edge after DONE → `init_done` clears and the sequence restarts from buffer 0.
- `freeze_in`=0101 idle → `freeze_out`=0101; during busy → 1111; after DONE → 0101.
- Assert `axi_reset` at write 10 with `init_spy_mem` held high → all outputs 0 immediately; after release, no start until `init_spy_mem` goes 0→1.
- Macro defined, `skip_mask`=0110 → only buffers 0 and 3 written (16 writes). With `skip_mask`=1111 → DONE immediately after QUIESCE with 0 writes.
